// File: rtl/ota_trim_sar_ctrl_pkg.sv
// Shared types and helpers for the OTA offset-trim SAR controller.
// Holds the FSM state encoding, default parameters and small decision functions.
package ota_ctrl_pkg;

    localparam int TRIM_W_DEF = 6;
    localparam int SETTLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_DONE
    } ota_cal_state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // mask selects the live code bits so one helper serves every TRIM_W up to 8.
    function automatic logic is_rail(input logic [7:0] code, input logic [7:0] mask);
        return ((code & mask) == 8'd0) || ((code & mask) == mask);
    endfunction

endpackage

// File: rtl/ota_trim_sar_ctrl_if.sv
// Control bus between the tile top (master) and the trim controller (slave).
// Carries start/manual-write requests in and the trim code plus status out.
interface ota_trim_sar_ctrl_if #(
    parameter int TRIM_W = ota_ctrl_pkg::TRIM_W_DEF
);
    logic              start;
    logic              trim_wr;
    logic [TRIM_W-1:0] trim_wdata;
    logic [TRIM_W-1:0] trim_code;
    logic              cal_en;
    logic              busy;
    logic              done;
    logic              sat;

    modport master (
        output start, trim_wr, trim_wdata,
        input  trim_code, cal_en, busy, done, sat
    );

    modport slave (
        input  start, trim_wr, trim_wdata,
        output trim_code, cal_en, busy, done, sat
    );
endinterface

// File: rtl/ota_trim_sar_ctrl_cmp_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs (comparator and other tile pins).
// Output is the last stage of a STAGES-deep chain cleared by rst.
module cmp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= (sync_q << 1) | STAGES'(d);
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/ota_trim_sar_ctrl.sv
// Offset-trim controller for the 5T OTA: shorts the inputs, then runs a
// majority-voted successive-approximation search on the trim DAC code.
module ota_trim_sar_ctrl
    import ota_ctrl_pkg::*;
#(
    parameter int TRIM_W        = TRIM_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cmp_in,
    ota_trim_sar_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam int IDX_W = $clog2(TRIM_W);
    localparam logic [TRIM_W-1:0] MIDSCALE  = TRIM_W'(1) << (TRIM_W - 1);
    localparam logic [7:0]        CODE_MASK = 8'((1 << TRIM_W) - 1);

    ota_cal_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [2:0]        vote_q;
    logic [TRIM_W-1:0] trim_code_q, decided_code;
    logic              cal_en_q, busy_q, done_q, sat_q;
    logic              cmp_s;

    cmp_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        decided_code = trim_code_q;
        if (maj3(vote_q)) decided_code[idx_q] = 1'b0;
        if (idx_q != '0)  decided_code[idx_q - IDX_W'(1)] = 1'b1;

        unique case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
            ST_SAMPLE: if (cnt_q == CNT_W'(2)) state_d = ST_DECIDE;
            ST_DECIDE: state_d = (idx_q == '0) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trim_code_q <= MIDSCALE;
            cal_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            vote_q      <= '0;
        end else begin
            // Status flags are registered from the next state so they align with it.
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.trim_wr && !bus.start) trim_code_q <= bus.trim_wdata;
                end
                ST_LOAD: begin
                    trim_code_q <= MIDSCALE;
                    cal_en_q    <= 1'b1;
                    sat_q       <= 1'b0;
                    idx_q       <= IDX_W'(TRIM_W - 1);
                    cnt_q       <= '0;
                end
                ST_SETTLE: begin
                    cnt_q <= (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
                end
                ST_SAMPLE: begin
                    vote_q <= {vote_q[1:0], cmp_s};
                    cnt_q  <= (cnt_q == CNT_W'(2)) ? '0 : cnt_q + CNT_W'(1);
                end
                ST_DECIDE: begin
                    trim_code_q <= decided_code;
                    if (idx_q != '0) idx_q <= idx_q - IDX_W'(1);
                end
                ST_DONE: begin
                    cal_en_q <= 1'b0;
                    sat_q    <= is_rail(8'(trim_code_q), CODE_MASK);
                end
                default: ;
            endcase
        end
    end

    assign bus.trim_code = trim_code_q;
    assign bus.cal_en    = cal_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_ota_trim_sar_ctrl.sv
// Directed bench for ota_trim_sar_ctrl: a behavioural OTA comparator model
// (cmp = code > target) closes the loop; expected values are hand-derived.
module tb_ota_trim_sar_ctrl;
    localparam int TW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_in = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    ota_trim_sar_ctrl_if #(.TRIM_W(TW)) bus ();

    ota_trim_sar_ctrl #(.TRIM_W(TW), .SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmp_in (cmp_in),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Results of one calibration run, observed on falling edges; k counts cycles after the start edge.
    logic [TW-1:0] r_code, r_code_k1, r_code_k2;
    logic          r_cal_mid, r_cal_after, r_busy_after, r_sat;
    int            r_done_k, r_busy_n, r_done_n;

    task automatic run_cal(input int target, input bit noise, input int wr_k, input int start_k,
                           input bit wr_with_start, input logic [TW-1:0] wdata);
        r_done_k = -1; r_busy_n = 0; r_done_n = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.trim_wr    = wr_with_start;
        bus.trim_wdata = wdata;
        cmp_in = (int'(bus.trim_code) > target);
        for (int k = 1; k <= 126; k++) begin
            @(negedge clk);
            bus.start      = (k == start_k);
            bus.trim_wr    = (k == wr_k);
            bus.trim_wdata = 6'd5;
            cmp_in = (int'(bus.trim_code) > target);
            if (noise && k >= 17 && k <= 117 && ((k - 17) % 20) == 0) cmp_in = ~cmp_in;
            if (bus.busy) r_busy_n++;
            if (bus.done) begin r_done_n++; r_done_k = k; end
            if (k == 1)   r_code_k1 = bus.trim_code;
            if (k == 2)   r_code_k2 = bus.trim_code;
            if (k == 50)  r_cal_mid = bus.cal_en;
            if (k == 123) begin
                r_code = bus.trim_code; r_cal_after = bus.cal_en;
                r_busy_after = bus.busy; r_sat = bus.sat;
            end
        end
    endtask

    task automatic check_timing(input string tag);
        total_cnt++;
        if (r_done_k !== 122) $display("FAIL %s done_cycle: got %0d expected 122", tag, r_done_k);
        else pass_cnt++;
        total_cnt++;
        if (r_done_n !== 1) $display("FAIL %s done_count: got %0d expected 1", tag, r_done_n);
        else pass_cnt++;
        total_cnt++;
        if (r_busy_n !== 122) $display("FAIL %s busy_cycles: got %0d expected 122", tag, r_busy_n);
        else pass_cnt++;
    endtask

    task automatic check_result(input string tag, input logic [TW-1:0] code, input logic sat);
        total_cnt++;
        if (r_code !== code) $display("FAIL %s trim_code: got %0d expected %0d", tag, r_code, code);
        else pass_cnt++;
        total_cnt++;
        if (r_sat !== sat) $display("FAIL %s sat: got %0b expected %0b", tag, r_sat, sat);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.trim_code !== 6'd32) $display("FAIL reset trim_code: got %0d expected 32", bus.trim_code);
        else pass_cnt++;
        total_cnt++;
        if ({bus.cal_en, bus.busy, bus.done, bus.sat} !== 4'b0000)
            $display("FAIL reset flags cal/busy/done/sat: got %4b expected 0000",
                     {bus.cal_en, bus.busy, bus.done, bus.sat});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_target37();
        run_cal(37, 1'b0, -1, -1, 1'b0, 6'd0);
        check_timing("target37");
        check_result("target37", 6'd37, 1'b0);
        total_cnt++;
        if (r_cal_mid !== 1'b1) $display("FAIL target37 cal_en_mid: got %0b expected 1", r_cal_mid);
        else pass_cnt++;
        total_cnt++;
        if ({r_cal_after, r_busy_after} !== 2'b00)
            $display("FAIL target37 cal_en/busy_after: got %2b expected 00", {r_cal_after, r_busy_after});
        else pass_cnt++;
    endtask

    task automatic test_rails();
        run_cal(63, 1'b0, -1, -1, 1'b0, 6'd0);
        check_result("rail_high", 6'd63, 1'b1);
        run_cal(-1, 1'b0, -1, -1, 1'b0, 6'd0);
        check_result("rail_low", 6'd0, 1'b1);
    endtask

    task automatic test_idle_write();
        @(negedge clk);
        bus.trim_wr = 1'b1; bus.trim_wdata = 6'd5;
        @(negedge clk);
        bus.trim_wr = 1'b0;
        total_cnt++;
        if (bus.trim_code !== 6'd5) $display("FAIL idle_write trim_code: got %0d expected 5", bus.trim_code);
        else pass_cnt++;
        total_cnt++;
        if (bus.sat !== 1'b1) $display("FAIL idle_write sat_kept: got %0b expected 1", bus.sat);
        else pass_cnt++;
    endtask

    task automatic test_start_with_write();
        run_cal(37, 1'b0, -1, -1, 1'b1, 6'd9);
        total_cnt++;
        if (r_code_k1 !== 6'd5) $display("FAIL start_wr load_cycle_code: got %0d expected 5", r_code_k1);
        else pass_cnt++;
        total_cnt++;
        if (r_code_k2 !== 6'd32) $display("FAIL start_wr first_trial_code: got %0d expected 32", r_code_k2);
        else pass_cnt++;
        check_timing("start_wr");
        check_result("start_wr", 6'd37, 1'b0);
    endtask

    task automatic test_noise();
        run_cal(37, 1'b1, -1, -1, 1'b0, 6'd0);
        check_result("noise", 6'd37, 1'b0);
        check_timing("noise");
    endtask

    task automatic test_busy_ignore();
        run_cal(37, 1'b0, 60, 70, 1'b0, 6'd0);
        check_timing("busy_ignore");
        check_result("busy_ignore", 6'd37, 1'b0);
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        cmp_in = (int'(bus.trim_code) > 20);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            cmp_in = (int'(bus.trim_code) > 20);
        end
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.trim_code !== 6'd32) $display("FAIL reset_mid trim_code: got %0d expected 32", bus.trim_code);
        else pass_cnt++;
        total_cnt++;
        if ({bus.busy, bus.done, bus.cal_en} !== 3'b000)
            $display("FAIL reset_mid busy/done/cal_en: got %3b expected 000", {bus.busy, bus.done, bus.cal_en});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        total_cnt++;
        if (done_seen !== 0) $display("FAIL reset_mid activity_after: got %0d expected 0", done_seen);
        else pass_cnt++;
        run_cal(37, 1'b0, -1, -1, 1'b0, 6'd0);
        check_timing("after_reset");
        check_result("after_reset", 6'd37, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.trim_wr = 1'b0; bus.trim_wdata = '0;
        test_reset();
        test_target37();
        test_rails();
        test_idle_write();
        test_start_with_write();
        test_noise();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ota_trim_sar_ctrl.md
Name: ota_trim_sar_ctrl

Overview:
- Digital offset-trim controller for the 5-transistor OTA macro.
- During calibration it shorts the OTA inputs (cal_en) and reads the OTA output as a comparator through a digital input pin.
- It then runs a successive-approximation search on a TRIM_W-bit trim code that drives the OTA's trim DAC switches.
- It sits beside the OTA in the tile top: start and manual-write controls come from ui_in, and trim_code, cal_en, busy and done go to uo_out and uio_out.

Parameters:
- TRIM_W, 6: trim code width, legal range 2..8.
- SETTLE_CYCLES, 16: analog settle wait per trial bit, minimum 3 (covers the synchroniser delay).
- SYNC_STAGES, 2: flop stages on cmp_in.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level-sampled request to begin calibration; acted on only in IDLE.
- cmp_in  in  1  asynchronous OTA output pin; 1 means offset positive, i.e. trial code too high.
- trim_wr  in  1  manual load strobe; acted on only in IDLE.
- trim_wdata  in  TRIM_W  manual trim value.
- trim_code  out  TRIM_W  registered code to the OTA trim switches.
- cal_en  out  1  registered; 1 = inputs shorted for calibration.
- busy  out  1  registered; 1 in any state other than IDLE.
- done  out  1  one-cycle pulse when calibration completes.
- sat  out  1  sticky flag: last calibration ended at all-zeros or all-ones.

Behaviour:
- Reset, async assert, any state: go to IDLE.
  - trim_code = 1<<(TRIM_W-1) (midscale).
  - cal_en=0, busy=0, done=0, sat=0; synchroniser flops=0.
  - Reset mid-calibration abandons the search; no done pulse.
- States: IDLE, LOAD, SETTLE, SAMPLE, DECIDE, DONE.
- IDLE:
  - start=1: go to LOAD. start has priority over trim_wr in the same cycle; that trim_wr is dropped.
  - trim_wr=1 with start=0: trim_code <= trim_wdata next cycle. sat is unchanged.
- LOAD (1 cycle): trim_code <= 1<<(TRIM_W-1); cal_en<=1; sat<=0; bit index idx<=TRIM_W-1; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (3 cycles): capture the synchronised cmp each cycle into a 3-bit vote register.
- DECIDE (1 cycle):
  - Vote = majority of the 3 samples.
  - Vote=1: clear trim_code[idx]. Vote=0: keep it.
  - idx>0: set trim_code[idx-1], idx<=idx-1, go to SETTLE.
  - idx==0: go to DONE.
- DONE (1 cycle): done=1; cal_en<=0; sat<=1 if trim_code is all-0 or all-1; go to IDLE.
- Latency: start sampled high in IDLE at edge N gives done=1 in cycle N + 2 + TRIM_W*(SETTLE_CYCLES+4). Defaults: N+122.
- busy=1 from the LOAD cycle through the DONE cycle inclusive.
- start or trim_wr while busy: ignored, with no queuing.
- trim_code changes only in LOAD, DECIDE, or on an IDLE trim_wr. It is glitch-free because it is a direct register output.
- start held high: a new calibration begins on the cycle after DONE returns to IDLE.
- Result: the largest code c such that the comparator reads 0 at c. If every trial reads 1, the result is 0.

Decomposition:
- Package ota_ctrl_pkg holds:
  - state enum ota_cal_state_t.
  - constants TRIM_W_DEF and SETTLE_DEF.
  - function maj3.
  - function is_rail(code), returning all-0 or all-1.
- Sub-module cmp_sync: SYNC_STAGES-deep flop chain on cmp_in, reset to 0 asynchronously by rst. It is reused for the other pad inputs of the tile.

Test Plan:
- Reset midscale: assert rst for 3 cycles -> trim_code=6'd32, cal_en=0, busy=0, done=0, sat=0.
- Target 37: model cmp_in = (trim_code > 37) and pulse start -> busy for 122 cycles, done pulses once at N+122, trim_code=37, sat=0, cal_en low after DONE.
- Rail high: cmp_in tied 0 -> trim_code=63, sat=1. Rail low: cmp_in tied 1 -> trim_code=0, sat=1.
- Noise rejection: target 37, but inject a single-cycle cmp_in inversion inside every SAMPLE window -> majority vote still yields trim_code=37.
- Ignored inputs:
  - trim_wr=1, trim_wdata=5 while busy -> no effect, result 37.
  - start pulse mid-calibration -> no restart.
  - trim_wr with 5 in IDLE -> trim_code=5 next cycle.
  - start and trim_wr in the same IDLE cycle -> calibration runs and the write is dropped.
- Reset mid-operation: assert rst during the third SETTLE -> immediately trim_code=32, busy=0, no done pulse. After release, a new start completes normally.
